trace_buffer: RTL and testbench
===============================

// Module: trace_buffer
// PURPOSE
//  Double-buffered store of per-row wall traces {side, size} feeding row_render.
//  Tracer fills the back bank through a valid/ready handshake. Display reads the front bank by row index.
//  Banks swap at frame start, so row_render never shows a partially traced frame.
// PARAMETERS
//  ROWS      480  rows per frame (trace entries per bank)
//  SIZE_W    11   width of size field (matches row_render size input)
//  ROW_W     10   width of row index (matches vpos)
// PORTS
//  clk            in   1       system/pixel clock
//  reset_n        in   1       asynchronous, active-low reset
//  wr_valid       in   1       tracer presents a trace
//  wr_ready       out  1       buffer accepts a trace this cycle
//  wr_side        in   1       wall side (shade select)
//  wr_size        in   SIZE_W  wall height for the row
//  vsync          in   1       vertical sync level from vga_sync (active-high)
//  rd_row         in   ROW_W   row index being displayed (vpos)
//  rd_side        out  1       front-bank side for rd_row
//  rd_size        out  SIZE_W  front-bank size for rd_row
//  rd_valid       out  1       front bank holds a complete frame
//  frame_swapped  out  1       one-cycle pulse when banks swap
// BEHAVIOUR
//  - Reset (async on reset_n low, any time, mid-fill included) clears:
//    wr_ptr=0, back_full=0, bank_sel=0, vsync_q=0, rd_valid=0,
//    rd_side=0, rd_size=0, frame_swapped=0. wr_ready rises the first cycle after release. RAM contents are not reset.
//  - Write: a transfer occurs on wr_valid & wr_ready. The entry goes to back bank [wr_ptr]; wr_ptr increments.
//    On the transfer at wr_ptr==ROWS-1: wr_ptr wraps to 0 and back_full is set.
//    wr_ready = ~back_full (combinational). Data held while wr_valid & ~wr_ready is not sampled.
//  - Frame start = rising edge of vsync (vsync & ~vsync_q), detected with one register.
//  - Swap: at frame start, if back_full_next (back_full, or the final-row transfer in this same cycle):
//    bank_sel toggles, back_full clears, wr_ptr=0, rd_valid=1, frame_swapped pulses for 1 cycle.
//    Otherwise no swap: the front bank is shown again (stale frame) and filling continues.
//  - Partial-fill swap never happens. Writes accepted in the swap cycle land in the old back bank, now the front:
//    only possible on the completing transfer itself.
//  - Read: 1-cycle latency. rd_side/rd_size are registered from front bank [rd_row].
//    If rd_row >= ROWS or rd_valid==0: rd_side=0, rd_size=0.
//    A read in the swap cycle uses the pre-swap bank_sel; the new bank is visible from the next cycle.
//  - Widths: wr_ptr ROW_W bits, never exceeds ROWS-1. No arithmetic on size (pass-through).
// CONFIGURATION
//  `TRACE_BUFFER_STATS_EN defined: adds output stale_frames [7:0].
//    Increments (saturating at 255) on each frame start without a swap while rd_valid==1.
//    Reset to 0.
//  Undefined: port and counter absent. All other behaviour identical.
// STRUCTURE
//  - rbzero_pkg: ROWS_DEFAULT=480, SIZE_W=11, ROW_W=10, typedef trace_t {logic side; logic [SIZE_W-1:0] size}.
//  - Sub-module trace_bank_ram: 2*ROWS x (SIZE_W+1) simple dual-port RAM
//    (1 write port, 1 registered read port, address = {bank, row}).
//  - Top holds the write pointer, full flag, vsync edge detect, bank select and optional stats counter.
// TESTING
//  1 Reset: assert reset_n=0 mid-fill (wr_ptr=200)
//    -> next cycle wr_ptr=0, rd_valid=0, rd_size=0, wr_ready=1 after release.
//  2 Fill: write 480 traces size=row, side=row[0]; then vsync rise
//    -> frame_swapped=1 one cycle; rd_row=37 gives rd_size=37, rd_side=1, one cycle later.
//  3 Back-pressure: after 480 writes with no vsync -> wr_ready=0; wr_valid held 10 cycles, no write.
//    vsync rise -> wr_ready=1 next cycle.
//  4 Stale frame: only 300 writes before vsync rise -> no swap, front data unchanged, wr_ptr continues at 300;
//    with STATS_EN stale_frames=1.
//  5 Coincidence: 480th transfer in the same cycle as the vsync rise -> swap occurs, rd_valid=1, wr_ptr=0.
//  6 Range: rd_row=500 -> rd_size=0, rd_side=0 (1-cycle latency).
//    Before first swap, any rd_row -> rd_size=0.

Source files
------------

// File: rtl/trace_buffer_pkg.sv
// Shared widths and the trace entry type for the double-buffered row trace store.
package trace_buffer_pkg;

    localparam int ROWS_DEFAULT = 480;
    localparam int SIZE_W       = 11;
    localparam int ROW_W        = 10;

    typedef struct packed {
        logic              side;
        logic [SIZE_W-1:0] size;
    } trace_t;

    localparam int TRACE_W = $bits(trace_t);

endpackage

// File: rtl/trace_buffer_if.sv
// Tracer write handshake plus display read/sync signals of the trace buffer.
interface trace_buffer_if;
    import trace_buffer_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic              wr_side;
    logic [SIZE_W-1:0] wr_size;
    logic              vsync;
    logic [ROW_W-1:0]  rd_row;
    logic              rd_side;
    logic [SIZE_W-1:0] rd_size;
    logic              rd_valid;
    logic              frame_swapped;

    modport master (
        output wr_valid, wr_side, wr_size, vsync, rd_row,
        input  wr_ready, rd_side, rd_size, rd_valid, frame_swapped
    );

    modport slave (
        input  wr_valid, wr_side, wr_size, vsync, rd_row,
        output wr_ready, rd_side, rd_size, rd_valid, frame_swapped
    );

endinterface

// File: rtl/trace_buffer_bank_ram.sv
// Simple dual-port RAM holding both trace banks; one write port, one registered read port.
module trace_buffer_bank_ram
    import trace_buffer_pkg::*;
#(
    parameter int DEPTH = 2 * ROWS_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  trace_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output trace_t        rd_data
);

    trace_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trace_buffer.sv
// Double-buffered per-row wall trace store: tracer fills the back bank, display reads the front.
// Optional stale-frame counter output enabled by defining TRACE_BUFFER_STATS_EN.
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    trace_buffer_if.slave bus
`ifdef TRACE_BUFFER_STATS_EN
    ,
    output logic [7:0]    stale_frames
`endif
);

    localparam int RAM_DEPTH = 2 * ROWS;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]   ROW_LIMIT = (ROW_W + 1)'(ROWS);

    logic [ROW_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             back_full_q, back_full_d;
    logic             bank_sel_q, bank_sel_d;
    logic             vsync_q;
    logic             rd_valid_q, rd_valid_d;
    logic             frame_swapped_q, frame_swapped_d;
    logic             rd_gate_q;

    logic             wr_fire;
    logic             last_fire;
    logic             frame_start;
    logic             swap;
    logic             rd_in_range;
    logic [RAM_AW-1:0] wr_addr;
    logic [RAM_AW-1:0] rd_addr;
    trace_t           wr_data;
    trace_t           ram_q;

    // Bank 0 occupies rows [0, ROWS), bank 1 occupies [ROWS, 2*ROWS).
    function automatic logic [RAM_AW-1:0] bank_addr(input logic bank, input logic [ROW_W-1:0] row);
        return RAM_AW'(row) + (bank ? RAM_AW'(ROWS) : '0);
    endfunction

    always_comb begin
        wr_fire     = bus.wr_valid & ~back_full_q;
        last_fire   = wr_fire & (wr_ptr_q == LAST_ROW);
        frame_start = bus.vsync & ~vsync_q;
        swap        = frame_start & (back_full_q | last_fire);
        rd_in_range = ({1'b0, bus.rd_row} < ROW_LIMIT);

        wr_ptr_d        = wr_ptr_q;
        back_full_d     = back_full_q;
        bank_sel_d      = bank_sel_q;
        rd_valid_d      = rd_valid_q;
        frame_swapped_d = 1'b0;

        if (wr_fire) begin
            wr_ptr_d = last_fire ? '0 : wr_ptr_q + 1'b1;
        end
        if (last_fire) begin
            back_full_d = 1'b1;
        end
        if (swap) begin
            bank_sel_d      = ~bank_sel_q;
            back_full_d     = 1'b0;
            wr_ptr_d        = '0;
            rd_valid_d      = 1'b1;
            frame_swapped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            back_full_q     <= 1'b0;
            bank_sel_q      <= 1'b0;
            vsync_q         <= 1'b0;
            rd_valid_q      <= 1'b0;
            frame_swapped_q <= 1'b0;
            rd_gate_q       <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            back_full_q     <= back_full_d;
            bank_sel_q      <= bank_sel_d;
            vsync_q         <= bus.vsync;
            rd_valid_q      <= rd_valid_d;
            frame_swapped_q <= frame_swapped_d;
            // Gate uses pre-swap validity so the swap-cycle read matches the old front bank.
            rd_gate_q       <= rd_in_range & rd_valid_q;
        end
    end

    // The write bank is always the one not being displayed, even during the swap cycle.
    assign wr_addr      = bank_addr(~bank_sel_q, wr_ptr_q);
    assign rd_addr      = rd_in_range ? bank_addr(bank_sel_q, bus.rd_row) : '0;
    assign wr_data.side = bus.wr_side;
    assign wr_data.size = bus.wr_size;

    trace_buffer_bank_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    assign bus.wr_ready      = ~back_full_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.frame_swapped = frame_swapped_q;
    assign bus.rd_side       = rd_gate_q & ram_q.side;
    assign bus.rd_size       = rd_gate_q ? ram_q.size : '0;

`ifdef TRACE_BUFFER_STATS_EN
    logic [7:0] stale_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stale_q <= '0;
        end else if (frame_start && !swap && rd_valid_q && (stale_q != 8'hFF)) begin
            stale_q <= stale_q + 8'd1;
        end
    end

    assign stale_frames = stale_q;
`endif

endmodule

// File: tb/tb_trace_buffer.sv
// Randomised and directed bench for trace_buffer against a frame-level queue model.
module tb_trace_buffer;
    import trace_buffer_pkg::*;

    localparam int ROWS = ROWS_DEFAULT;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    trace_buffer_if bus();

`ifdef TRACE_BUFFER_STATS_EN
    logic [7:0] stale_frames;
`endif

    trace_buffer #(.ROWS(ROWS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef TRACE_BUFFER_STATS_EN
        ,
        .stale_frames (stale_frames)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame-level model: the back frame is a queue of accepted traces, the front a completed copy.
    trace_t back_q[$];
    trace_t front_m [ROWS];
    bit     front_ok    = 1'b0;
    bit     vs_prev     = 1'b0;
    int     stale_m     = 0;
    bit     exp_swapped = 1'b0;
    trace_t exp_rd      = '0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                back_q.delete();
                front_ok    = 1'b0;
                vs_prev     = 1'b0;
                stale_m     = 0;
                exp_swapped = 1'b0;
                exp_rd      = '0;
            end else begin
                trace_t t;
                bit     fs;
                if (front_ok && int'(bus.rd_row) < ROWS) exp_rd = front_m[bus.rd_row];
                else exp_rd = '0;
                if (bus.wr_valid && back_q.size() < ROWS) begin
                    t.side = bus.wr_side;
                    t.size = bus.wr_size;
                    back_q.push_back(t);
                end
                fs          = bus.vsync && !vs_prev;
                vs_prev     = bus.vsync;
                exp_swapped = 1'b0;
                if (fs && back_q.size() == ROWS) begin
                    for (int i = 0; i < ROWS; i++) front_m[i] = back_q[i];
                    back_q.delete();
                    front_ok    = 1'b1;
                    exp_swapped = 1'b1;
                end else if (fs && front_ok && stale_m < 255) begin
                    stale_m++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("wr_ready", 32'(bus.wr_ready), 32'(back_q.size() < ROWS));
                chk("rd_valid", 32'(bus.rd_valid), 32'(front_ok));
                chk("frame_swapped", 32'(bus.frame_swapped), 32'(exp_swapped));
                chk("rd_side", 32'(bus.rd_side), 32'(exp_rd.side));
                chk("rd_size", 32'(bus.rd_size), 32'(exp_rd.size));
`ifdef TRACE_BUFFER_STATS_EN
                chk("stale_frames", 32'(stale_frames), 32'(stale_m));
`endif
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic side, input logic [SIZE_W-1:0] size);
        next_cycle();
        bus.wr_valid = 1'b1;
        bus.wr_side  = side;
        bus.wr_size  = size;
    endtask

    task automatic wr_rand();
        wr(1'($urandom), SIZE_W'($urandom));
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_side  = 1'b0;
        bus.wr_size  = '0;
        bus.vsync    = 1'b0;
        bus.rd_row   = '0;
        repeat (3) next_cycle();
        reset_n = 1'b1;

        // Before any swap every read is blank.
        bus.rd_row = 10'd100;
        next_cycle();
        chk("pre_swap_rd_size", 32'(bus.rd_size), 32'd0);

        // Reset in the middle of a fill.
        for (int i = 0; i < 200; i++) wr_rand();
        next_cycle();
        bus.wr_valid = 1'b0;
        reset_n      = 1'b0;
        next_cycle();
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_size", 32'(bus.rd_size), 32'd0);
        chk("rst_frame_swapped", 32'(bus.frame_swapped), 32'd0);
        reset_n = 1'b1;
        next_cycle();
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Full frame of size=row, side=row[0], then frame start.
        for (int i = 0; i < ROWS; i++) wr(i[0], SIZE_W'(i));
        next_cycle();
        bus.wr_valid = 1'b0;
        bus.vsync    = 1'b1;
        next_cycle();
        bus.vsync = 1'b0;
        chk("swap_pulse", 32'(bus.frame_swapped), 32'd1);
        bus.rd_row = 10'd37;
        next_cycle();
        chk("swap_pulse_end", 32'(bus.frame_swapped), 32'd0);
        chk("row37_size", 32'(bus.rd_size), 32'd37);
        chk("row37_side", 32'(bus.rd_side), 32'd1);
        bus.rd_row = 10'd500;
        next_cycle();
        chk("row500_size", 32'(bus.rd_size), 32'd0);
        chk("row500_side", 32'(bus.rd_side), 32'd0);

        // Back-pressure once the back bank is full.
        for (int i = 0; i < ROWS; i++) wr_rand();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            chk("bp_wr_ready", 32'(bus.wr_ready), 32'd0);
            bus.wr_valid = 1'b1;
            bus.wr_side  = 1'($urandom);
            bus.wr_size  = SIZE_W'($urandom);
        end
        next_cycle();
        bus.wr_valid = 1'b0;
        bus.vsync    = 1'b1;
        next_cycle();
        bus.vsync = 1'b0;
        chk("bp_swap", 32'(bus.frame_swapped), 32'd1);
        chk("bp_ready_after_swap", 32'(bus.wr_ready), 32'd1);
        bus.rd_row = 10'd5;

        // Partial fill at frame start: stale frame, filling continues.
        for (int i = 0; i < 300; i++) wr_rand();
        next_cycle();
        bus.wr_valid = 1'b0;
        bus.vsync    = 1'b1;
        next_cycle();
        bus.vsync = 1'b0;
        chk("stale_no_swap", 32'(bus.frame_swapped), 32'd0);
`ifdef TRACE_BUFFER_STATS_EN
        chk("stale_count", 32'(stale_frames), 32'd1);
`endif

        // Completing transfer coincides with the frame start.
        for (int i = 0; i < ROWS - 301; i++) wr_rand();
        wr_rand();
        bus.vsync = 1'b1;
        next_cycle();
        bus.wr_valid = 1'b0;
        bus.vsync    = 1'b0;
        chk("coinc_swap", 32'(bus.frame_swapped), 32'd1);
        chk("coinc_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("coinc_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Random traffic with sparse frame starts.
        for (int i = 0; i < 4000; i++) begin
            next_cycle();
            bus.wr_valid = ($urandom_range(0, 9) < 7);
            bus.wr_side  = 1'($urandom);
            bus.wr_size  = SIZE_W'($urandom);
            bus.rd_row   = ROW_W'($urandom_range(0, 511));
            if ($urandom_range(0, 299) == 0) bus.vsync = ~bus.vsync;
        end
        next_cycle();
        bus.wr_valid = 1'b0;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
